// File: rtl/router_src_ingress.sv
// Source-side router ingress: decodes the header, steers every byte to one of NUM_DEST FIFOs,
// and checks length and parity. Optional statistics counters are enabled with ROUTER_SRC_STATS_EN.
module router_src_ingress #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_DEST = 3,
  parameter int unsigned LEN_W    = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   din,
  input  logic                pkt_valid,
  output logic                busy,
  output logic                error,
  output logic                pkt_done,
  output logic [DATA_W-1:0]   fifo_wdata,
  output logic [NUM_DEST-1:0] fifo_we,
  input  logic [NUM_DEST-1:0] fifo_full
`ifdef ROUTER_SRC_STATS_EN
  ,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         err_cnt
`endif
);

  localparam int unsigned ADDR_W = $clog2(NUM_DEST);

  if (ADDR_W + LEN_W > DATA_W) begin : g_bad_header_width
    $error("router_src_ingress: ADDR_W + LEN_W must not exceed DATA_W");
  end
  if (NUM_DEST < 2) begin : g_bad_num_dest
    $error("router_src_ingress: NUM_DEST must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StHdrWait,
    StPayload,
    StParity,
    StCheck,
    StDrop
  } state_e;

  function automatic logic [NUM_DEST-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_DEST-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_DEST; i++) begin
      if (idx == ADDR_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   hdr_q, hdr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   par_q, par_d;
  logic                len_err_q, len_err_d;
  logic                error_q, error_d;

  logic [ADDR_W-1:0]   in_dest;
  logic [LEN_W-1:0]    in_len;
  logic                in_dest_bad;
  logic                in_full;
  logic                sel_full;
  logic                we_c;
  logic [ADDR_W-1:0]   we_dest;
  logic [DATA_W-1:0]   wdata_c;
  logic                busy_c;
  logic                done_c;

  assign in_dest     = din[ADDR_W-1:0];
  assign in_len      = din[ADDR_W+LEN_W-1:ADDR_W];
  assign in_dest_bad = (32'(in_dest) >= NUM_DEST);
  assign in_full     = |(fifo_full & onehot(in_dest));
  assign sel_full    = |(fifo_full & onehot(dest_q));

  // par_q accumulates XOR of all bytes including the parity byte; nonzero means mismatch.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    len_err_d = len_err_q;
    error_d   = error_q;
    we_c      = 1'b0;
    we_dest   = dest_q;
    wdata_c   = din;
    busy_c    = 1'b0;
    done_c    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pkt_valid) begin
          hdr_d     = din;
          dest_d    = in_dest;
          cnt_d     = in_len;
          par_d     = din;
          len_err_d = 1'b0;
          error_d   = 1'b0;
          if (in_dest_bad) begin
            state_d = StDrop;
          end else if (in_full) begin
            state_d = StHdrWait;
          end else begin
            we_c    = 1'b1;
            we_dest = in_dest;
            state_d = (in_len == '0) ? StParity : StPayload;
          end
        end
      end
      StHdrWait: begin
        busy_c = 1'b1;
        if (!sel_full) begin
          we_c    = 1'b1;
          wdata_c = hdr_q;
          state_d = (cnt_q == '0) ? StParity : StPayload;
        end
      end
      StPayload: begin
        busy_c = sel_full;
        if (!sel_full) begin
          we_c  = 1'b1;
          par_d = par_q ^ din;
          if (pkt_valid) begin
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_d = StParity;
          end else begin
            // Packet ended early: this byte is its parity.
            len_err_d = 1'b1;
            state_d   = StCheck;
          end
        end
      end
      StParity: begin
        busy_c = sel_full;
        if (!sel_full) begin
          we_c  = 1'b1;
          par_d = par_q ^ din;
          if (pkt_valid) len_err_d = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        error_d = (|par_q) | len_err_q;
        state_d = StIdle;
      end
      StDrop: begin
        if (!pkt_valid) begin
          done_c  = 1'b1;
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      dest_q    <= '0;
      hdr_q     <= '0;
      cnt_q     <= '0;
      par_q     <= '0;
      len_err_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      hdr_q     <= hdr_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      len_err_q <= len_err_d;
      error_q   <= error_d;
    end
  end

  // Gate writes with reset so a header on din cannot leak through while reset is held.
  assign fifo_we    = (we_c && !reset) ? onehot(we_dest) : '0;
  assign fifo_wdata = (we_c && !reset) ? wdata_c : '0;
  assign busy       = busy_c;
  assign pkt_done   = done_c;
  assign error      = error_q;

`ifdef ROUTER_SRC_STATS_EN
  logic [15:0] pkt_cnt_q, err_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (done_c) begin
      if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (error_d && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_src_ingress.sv
// Randomized bench for router_src_ingress: a packet-level model predicts every FIFO write and
// the per-packet error flag; a single compare process checks the DUT on every cycle.
module tb_router_src_ingress;

  typedef struct {
    logic [1:0] dest;
    logic [7:0] data;
  } wr_t;

  logic       clock;
  logic       reset;
  logic [7:0] din;
  logic       pkt_valid;
  logic       busy;
  logic       error;
  logic       pkt_done;
  logic [7:0] fifo_wdata;
  logic [2:0] fifo_we;
  logic [2:0] fifo_full;

  int  checks;
  int  failures;
  wr_t exp_wr[$];
  bit  exp_err[$];
  logic [7:0] pl[$];
  int  wr_cnt[3];
  int  done_cnt;
  bit  pending;
  bit  exp_e;
  int  force_full;
  bit  rand_full;

  router_src_ingress dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .pkt_valid  (pkt_valid),
    .busy       (busy),
    .error      (error),
    .pkt_done   (pkt_done),
    .fifo_wdata (fifo_wdata),
    .fifo_we    (fifo_we),
    .fifo_full  (fifo_full)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every write must match the head of the expected write stream, every
  // pkt_done must match an expected packet, and error is checked the cycle after pkt_done.
  always @(negedge clock) begin
    wr_t e;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        checks++;
        if (error !== exp_e) begin
          failures++;
          $display("FAIL pkt_error: got %0b expected %0b", error, exp_e);
        end
        pending = 1'b0;
      end
      if (fifo_we !== 3'b000) begin
        checks++;
        for (int i = 0; i < 3; i++) if (fifo_we[i]) wr_cnt[i]++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: we=%b data=%h, none expected", fifo_we, fifo_wdata);
        end else begin
          e = exp_wr.pop_front();
          if (fifo_we !== (3'b001 << e.dest) || fifo_wdata !== e.data) begin
            failures++;
            $display("FAIL write: got we=%b data=%h expected we=%b data=%h",
                     fifo_we, fifo_wdata, 3'b001 << e.dest, e.data);
          end
        end
      end
      if (pkt_done === 1'b1) begin
        checks++;
        done_cnt++;
        if (exp_err.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: pkt_done=1 with no packet outstanding");
        end else begin
          exp_e   = exp_err.pop_front();
          pending = 1'b1;
        end
      end
    end
  end

  // Hold a byte until a cycle with busy low has passed; count stalled cycles.
  task automatic send_byte(input logic [7:0] d, input logic v, output int stalls);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    stalls = 0;
    din = d;
    pkt_valid = v;
    while (!acc) begin
      if (force_full > 0) begin
        fifo_full = 3'b010;
        force_full--;
      end else if (rand_full) begin
        fifo_full = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      end else begin
        fifo_full = 3'b000;
      end
      @(negedge clock);
      acc = !busy;
      @(posedge clock);
      #1;
      if (!acc) stalls++;
      guard++;
      if (guard > 500) begin
        failures++;
        $display("FAIL busy_timeout: busy held for %0d cycles", guard);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "busy never released");
      end
    end
  endtask

  task automatic idle(input int n);
    pkt_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      din = 8'($urandom);
      fifo_full = rand_full ? 3'($urandom) : 3'b000;
      @(posedge clock);
      #1;
    end
  endtask

  // Packet-level model: valid destination -> header, payload, parity all land in that FIFO;
  // error if payload count differs from the header length or the XOR of all bytes is nonzero.
  task automatic model_push(input logic [7:0] hdr, input logic [7:0] par);
    logic [7:0] x;
    logic [1:0] dst;
    int len;
    wr_t w;
    x = hdr;
    foreach (pl[i]) x ^= pl[i];
    dst = hdr[1:0];
    len = int'(hdr[7:2]);
    if (dst == 2'd3) begin
      exp_err.push_back(1'b1);
    end else begin
      w.dest = dst;
      w.data = hdr;
      exp_wr.push_back(w);
      foreach (pl[i]) begin
        w.data = pl[i];
        exp_wr.push_back(w);
      end
      w.data = par;
      exp_wr.push_back(w);
      exp_err.push_back((pl.size() != len) || (x != par));
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input bit use_par, input logic [7:0] par_in,
                          output int stalls);
    logic [7:0] par;
    int s;
    par = hdr;
    foreach (pl[i]) par ^= pl[i];
    if (use_par) par = par_in;
    model_push(hdr, par);
    stalls = 0;
    send_byte(hdr, 1'b1, s);
    stalls += s;
    chk("error_clear_on_header", {31'd0, error}, 32'd0);
    foreach (pl[i]) begin
      send_byte(pl[i], 1'b1, s);
      stalls += s;
    end
    send_byte(par, 1'b0, s);
    stalls += s;
  endtask

  initial begin
    int st;
    int w0, w1, w2, d0;
    checks = 0;
    failures = 0;
    done_cnt = 0;
    pending = 1'b0;
    force_full = 0;
    rand_full = 1'b0;
    for (int i = 0; i < 3; i++) wr_cnt[i] = 0;
    reset = 1'b1;
    din = 8'h00;
    pkt_valid = 1'b0;
    fifo_full = 3'b000;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_fifo_we", {29'd0, fifo_we}, 32'd0);
    chk("rst_fifo_wdata", {24'd0, fifo_wdata}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Good packet to FIFO1.
    pl = {8'hA1, 8'hB2, 8'hC3};
    w1 = wr_cnt[1];
    d0 = done_cnt;
    send_pkt(8'h0D, 1'b1, 8'hDD, st);
    idle(3);
    chk("good_writes_fifo1", wr_cnt[1] - w1, 32'd5);
    chk("good_done", done_cnt - d0, 32'd1);
    chk("good_error", {31'd0, error}, 32'd0);

    // Bad parity.
    w1 = wr_cnt[1];
    send_pkt(8'h0D, 1'b1, 8'h00, st);
    idle(3);
    chk("badpar_writes_fifo1", wr_cnt[1] - w1, 32'd5);
    chk("badpar_error", {31'd0, error}, 32'd1);

    // FIFO1 full for the first 4 cycles of the packet.
    w1 = wr_cnt[1];
    force_full = 4;
    send_pkt(8'h0D, 1'b0, 8'h00, st);
    idle(3);
    chk("full_stalls", st, 32'd4);
    chk("full_writes_fifo1", wr_cnt[1] - w1, 32'd5);
    chk("full_error", {31'd0, error}, 32'd0);

    // Bad destination is dropped.
    pl = {8'h01, 8'h02, 8'h03};
    w0 = wr_cnt[0] + wr_cnt[1] + wr_cnt[2];
    d0 = done_cnt;
    send_pkt(8'h0F, 1'b0, 8'h00, st);
    idle(3);
    chk("drop_writes", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] - w0, 32'd0);
    chk("drop_done", done_cnt - d0, 32'd1);
    chk("drop_error", {31'd0, error}, 32'd1);

    // Short packet: L=4, only 2 payload bytes.
    pl = {8'h44, 8'h55};
    w0 = wr_cnt[0];
    send_pkt(8'h10, 1'b0, 8'h00, st);
    idle(3);
    chk("short_writes_fifo0", wr_cnt[0] - w0, 32'd4);
    chk("short_error", {31'd0, error}, 32'd1);

    // Reset in the middle of a payload.
    pl = {8'h11, 8'h22, 8'h33};
    model_push(8'h0C, 8'h00);
    send_byte(8'h0C, 1'b1, st);
    send_byte(8'h11, 1'b1, st);
    din = 8'h22;
    pkt_valid = 1'b1;
    fifo_full = 3'b000;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_fifo_we", {29'd0, fifo_we}, 32'd0);
    chk("midrst_error", {31'd0, error}, 32'd0);
    exp_wr.delete();
    exp_err.delete();
    pkt_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    pl.delete();
    w2 = wr_cnt[2];
    send_pkt(8'h02, 1'b1, 8'h02, st);
    idle(3);
    chk("after_rst_writes_fifo2", wr_cnt[2] - w2, 32'd2);
    chk("after_rst_error", {31'd0, error}, 32'd0);

    // Randomized packets with random back-pressure, short packets and bad destinations.
    rand_full = 1'b1;
    for (int p = 0; p < 200; p++) begin
      int len;
      int n;
      logic [1:0] dst;
      dst = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 8);
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len;
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_pkt({6'(len), dst}, ($urandom_range(0, 3) == 0), 8'($urandom), st);
      idle($urandom_range(0, 2));
    end
    rand_full = 1'b0;
    idle(10);
    chk("drain_writes", exp_wr.size(), 32'd0);
    chk("drain_packets", exp_err.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
